// File: rtl/ma_pkg.sv
// Shared defaults and types for the moving-average sample transmit path.
package ma_pkg;

  localparam int unsigned MA_DATA_W  = 8;
  localparam int unsigned MA_DEPTH   = 4;
  localparam int unsigned MA_DIV_W   = 8;
  localparam int unsigned MA_LEVEL_W = $clog2(MA_DEPTH) + 1;

  typedef logic [MA_DATA_W-1:0] sample_t;

endpackage

// File: rtl/ma_sample_fifo.sv
// Synchronous FIFO with a dedicated occupancy counter; head is read combinationally.
module ma_sample_fifo
  import ma_pkg::*;
#(
  parameter int unsigned DATA_W = MA_DATA_W,
  parameter int unsigned DEPTH  = MA_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ma_sample_tx.sv
// Paced sample transmitter: pops one FIFO entry every div+1 enabled cycles.
module ma_sample_tx
  import ma_pkg::*;
#(
  parameter int unsigned DATA_W = MA_DATA_W,
  parameter int unsigned DEPTH  = MA_DEPTH,
  parameter int unsigned DIV_W  = MA_DIV_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [DIV_W-1:0]       div,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      sample_out,
  output logic                   sample_strobe,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              strobe_q, strobe_d;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              push, pop;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  // Pop decision uses pre-edge occupancy, so a same-edge push is never popped.
  assign pop      = ena && (cnt_q == '0) && !fifo_empty;

  ma_sample_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(in_data),
    .pop  (pop),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(level)
  );

  always_comb begin
    cnt_d    = cnt_q;
    sample_d = sample_q;
    strobe_d = 1'b0;
    if (ena) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - DIV_W'(1);
      end else if (!fifo_empty) begin
        cnt_d    = div;
        sample_d = fifo_head;
        strobe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      sample_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      strobe_q <= strobe_d;
    end
  end

  assign sample_out    = sample_q;
  assign sample_strobe = strobe_q;
  assign busy          = (level != '0) || (cnt_q != '0);

endmodule

// File: tb/tb_ma_sample_tx.sv
// Directed, table-driven bench for ma_sample_tx with hand-computed expectations.
module tb_ma_sample_tx;
  import ma_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] div = '0;
  sample_t    in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  sample_t    sample_out;
  logic       sample_strobe;
  logic [2:0] level;
  logic       busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ma_sample_tx #(
    .DATA_W(8),
    .DEPTH (4),
    .DIV_W (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .div          (div),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sample_out   (sample_out),
    .sample_strobe(sample_strobe),
    .level        (level),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic [7:0] div;
    logic       valid;
    logic [7:0] din;
    logic       ready;
    logic       strobe;
    logic [7:0] sample;
    logic [2:0] level;
    logic       busy;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic e, logic [7:0] d, logic v, logic [7:0] din,
                              logic r, logic s, logic [7:0] smp, logic [2:0] lv, logic b);
    vec_t t;
    t.ena = e; t.div = d; t.valid = v; t.din = din;
    t.ready = r; t.strobe = s; t.sample = smp; t.level = lv; t.busy = b;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic r, input logic s,
                         input logic [7:0] smp, input logic [2:0] lv, input logic b);
    chk({tag, ".ready"},  32'(in_ready),      32'(r));
    chk({tag, ".strobe"}, 32'(sample_strobe), 32'(s));
    chk({tag, ".sample"}, 32'(sample_out),    32'(smp));
    chk({tag, ".level"},  32'(level),         32'(lv));
    chk({tag, ".busy"},   32'(busy),          32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp5 [8];

  initial begin
    // Tests 1-3: single push latency, div=3 pacing, ena freeze with full FIFO
    vecs[0]  = mk(1, 0, 1, 8'h11, 1, 0, 8'h00, 1, 1);
    vecs[1]  = mk(1, 0, 0, 8'h00, 1, 1, 8'h11, 0, 0);
    vecs[2]  = mk(1, 0, 0, 8'h00, 1, 0, 8'h11, 0, 0);
    vecs[3]  = mk(1, 3, 1, 8'h01, 1, 0, 8'h11, 1, 1);
    vecs[4]  = mk(1, 3, 1, 8'h02, 1, 1, 8'h01, 1, 1);
    vecs[5]  = mk(1, 3, 1, 8'h03, 1, 0, 8'h01, 2, 1);
    vecs[6]  = mk(1, 3, 0, 8'h00, 1, 0, 8'h01, 2, 1);
    vecs[7]  = mk(1, 3, 0, 8'h00, 1, 0, 8'h01, 2, 1);
    vecs[8]  = mk(1, 3, 0, 8'h00, 1, 1, 8'h02, 1, 1);
    vecs[9]  = mk(1, 3, 0, 8'h00, 1, 0, 8'h02, 1, 1);
    vecs[10] = mk(1, 3, 0, 8'h00, 1, 0, 8'h02, 1, 1);
    vecs[11] = mk(1, 3, 0, 8'h00, 1, 0, 8'h02, 1, 1);
    vecs[12] = mk(1, 3, 0, 8'h00, 1, 1, 8'h03, 0, 1);
    vecs[13] = mk(1, 3, 0, 8'h00, 1, 0, 8'h03, 0, 1);
    vecs[14] = mk(1, 3, 0, 8'h00, 1, 0, 8'h03, 0, 1);
    vecs[15] = mk(1, 3, 0, 8'h00, 1, 0, 8'h03, 0, 0);
    vecs[16] = mk(0, 0, 1, 8'hA1, 1, 0, 8'h03, 1, 1);
    vecs[17] = mk(0, 0, 1, 8'hA2, 1, 0, 8'h03, 2, 1);
    vecs[18] = mk(0, 0, 1, 8'hA3, 1, 0, 8'h03, 3, 1);
    vecs[19] = mk(0, 0, 1, 8'hA4, 0, 0, 8'h03, 4, 1);
    vecs[20] = mk(0, 0, 1, 8'hA5, 0, 0, 8'h03, 4, 1);
    vecs[21] = mk(1, 0, 0, 8'h00, 1, 1, 8'hA1, 3, 1);
    vecs[22] = mk(1, 0, 0, 8'h00, 1, 1, 8'hA2, 2, 1);
    vecs[23] = mk(1, 0, 0, 8'h00, 1, 1, 8'hA3, 1, 1);
    vecs[24] = mk(1, 0, 0, 8'h00, 1, 1, 8'hA4, 0, 0);
    vecs[25] = mk(1, 0, 0, 8'h00, 1, 0, 8'hA4, 0, 0);

    exp5[0] = 8'h10; exp5[1] = 8'h11; exp5[2] = 8'h12; exp5[3] = 8'h13;
    exp5[4] = 8'h7E; exp5[5] = 8'h7E; exp5[6] = 8'h7E; exp5[7] = 8'h7E;

    tick();
    tick();
    chk_all("reset", 1, 0, 8'h00, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      ena      = vecs[i].ena;
      div      = vecs[i].div;
      in_valid = vecs[i].valid;
      in_data  = vecs[i].din;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].ready, vecs[i].strobe,
              vecs[i].sample, vecs[i].level, vecs[i].busy);
    end

    // Test 4: ena freeze in the middle of a div=2 count
    ena = 1; div = 2; in_valid = 1; in_data = 8'hA5;
    tick();
    chk_all("t4.push", 1, 0, 8'hA4, 1, 1);
    in_data = 8'hB6;
    tick();
    chk_all("t4.emitA5", 1, 1, 8'hA5, 1, 1);
    in_valid = 0;
    tick();
    chk_all("t4.cnt1", 1, 0, 8'hA5, 1, 1);
    ena = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("t4.frz%0d", i), 1, 0, 8'hA5, 1, 1);
    end
    ena = 1;
    tick();
    chk_all("t4.cnt0", 1, 0, 8'hA5, 1, 1);
    tick();
    chk_all("t4.emitB6", 1, 1, 8'hB6, 0, 1);
    tick();
    tick();
    chk_all("t4.idle", 1, 0, 8'hB6, 0, 0);

    // Test 5: full FIFO, div=0, in_valid held -> push and pop every cycle
    ena = 0; div = 0; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h10 + i);
      tick();
    end
    chk_all("t5.full", 0, 0, 8'hB6, 4, 1);
    ena = 1; in_data = 8'h7E;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all($sformatf("t5.stream%0d", i), 1, 1, exp5[i], 3, 1);
    end
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("t5.drain%0d", i), 1, 1, 8'h7E, 3'(2 - i), 3'(2 - i) != 0);
    end
    tick();
    chk_all("t5.done", 1, 0, 8'h7E, 0, 0);

    // Test 6: asynchronous reset with level=3 and cnt=2
    ena = 0; div = 2; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'hC1 + i);
      tick();
    end
    ena = 1; in_valid = 0;
    tick();
    chk_all("t6.pre", 1, 1, 8'hC1, 3, 1);
    #3;
    rst = 1'b1;
    #1;
    chk_all("t6.async", 1, 0, 8'h00, 0, 0);
    tick();
    rst = 1'b0;
    div = 0; in_valid = 1; in_data = 8'hD1;
    tick();
    chk_all("t6.push", 1, 0, 8'h00, 1, 1);
    in_valid = 0;
    tick();
    chk_all("t6.emit", 1, 1, 8'hD1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
